// File: rtl/m_cpu_pkg.sv
// Shared CPU datapath definitions: register width, register count and index width.
// The register file and the rs1/rs2 read muxes both import this package.
package m_cpu_pkg;

    localparam int REG_W = 16;
    localparam int NREG  = 16;
    localparam int SEL_W = 4;

    typedef logic [REG_W-1:0] word_t;
    typedef logic [SEL_W-1:0] reg_idx_t;

endpackage : m_cpu_pkg

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for the register file: one pending-write bit per register,
// WAW issue guard and the rs1/rs2 stall/forward flags for decode.
module reg_scoreboard
    import m_cpu_pkg::*;
#(
    parameter int NREG = m_cpu_pkg::NREG,
    parameter int SEL  = m_cpu_pkg::SEL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [SEL-1:0]  wr_sel,
    input  logic            iss_valid,
    input  logic [SEL-1:0]  iss_rd,
    input  logic [SEL-1:0]  rs1_sel,
    input  logic [SEL-1:0]  rs2_sel,
    output logic            iss_ready,
    output logic [NREG-1:0] busy_o,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rs1_fwd,
    output logic            rs2_fwd
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            fire_s;

    // A pending write-back to the destination frees it in the same cycle.
    assign iss_ready = ~busy_r[iss_rd] | (wr_en & (wr_sel == iss_rd));
    assign fire_s    = iss_valid & iss_ready;

    assign rs1_fwd   = wr_en & (wr_sel == rs1_sel);
    assign rs2_fwd   = wr_en & (wr_sel == rs2_sel);
    assign rs1_busy  = busy_r[rs1_sel] & ~rs1_fwd;
    assign rs2_busy  = busy_r[rs2_sel] & ~rs2_fwd;
    assign busy_o    = busy_r;

    // Next busy vector: clear on write-back first, so a same-index issue sets it again.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_en) begin
            busy_nxt_s[wr_sel] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (fire_s) begin
            busy_nxt_s[iss_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

endmodule : reg_scoreboard

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit general register file with one write-back port; exports the whole
// array to the read muxes and wraps the busy scoreboard for decode/issue.
module reg_file_16x16
    import m_cpu_pkg::*;
#(
    parameter int N    = m_cpu_pkg::REG_W,
    parameter int NREG = m_cpu_pkg::NREG,
    parameter int SEL  = m_cpu_pkg::SEL_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [SEL-1:0]  wr_sel,
    input  logic [N-1:0]    wr_data,
    input  logic            iss_valid,
    input  logic [SEL-1:0]  iss_rd,
    output logic            iss_ready,
    input  logic [SEL-1:0]  rs1_sel,
    input  logic [SEL-1:0]  rs2_sel,
    output logic [N-1:0]    rf_o [NREG-1:0],
    output logic [NREG-1:0] busy_o,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rs1_fwd,
    output logic            rs2_fwd
);

    logic [N-1:0] rf_r [NREG-1:0];

    // Storage array: reset clears every entry, otherwise the write-back port updates one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wr_en) begin
            rf_r[wr_sel] <= wr_data;
        end else begin
            rf_r <= rf_r;
        end
    end

    assign rf_o = rf_r;

    reg_scoreboard #(
        .NREG (NREG),
        .SEL  (SEL)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1_sel   (rs1_sel),
        .rs2_sel   (rs2_sel),
        .iss_ready (iss_ready),
        .busy_o    (busy_o),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd)
    );

endmodule : reg_file_16x16

// File: tb/tb_reg_file_16x16.sv
// Self-checking bench for reg_file_16x16: hand-computed vector table for the
// directed scenarios, then random traffic against a behavioural model.
module tb_reg_file_16x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [15:0] wr_data;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic [3:0]  rs1_sel;
    logic [3:0]  rs2_sel;
    logic [15:0] rf_o [15:0];
    logic [15:0] busy_o;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs1_fwd;
    logic        rs2_fwd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  ws;
        logic [15:0] wd;
        logic        iv;
        logic [3:0]  ird;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        cc;
        logic        rdy;
        logic        r1b;
        logic        r1f;
        logic        r2b;
        logic        r2f;
        logic [3:0]  pidx;
        logic [15:0] pval;
        logic [15:0] pbusy;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        logic [15:0] busy;
    } post_t;

    post_t post_q[$];
    vec_t  tbl [19];

    logic [15:0] m_rf [16];
    logic [15:0] m_busy;

    reg_file_16x16 dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_sel   (rs1_sel),
        .rs2_sel   (rs2_sel),
        .rf_o      (rf_o),
        .busy_o    (busy_o),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic we, input logic [3:0] ws,
                                input logic [15:0] wd, input logic iv, input logic [3:0] ird,
                                input logic [3:0] r1, input logic [3:0] r2, input logic cc,
                                input logic rdy, input logic r1b, input logic r1f,
                                input logic r2b, input logic r2f, input logic [3:0] pidx,
                                input logic [15:0] pval, input logic [15:0] pbusy);
        vec_t v;
        v.rst = r; v.we = we; v.ws = ws; v.wd = wd; v.iv = iv; v.ird = ird;
        v.r1 = r1; v.r2 = r2; v.cc = cc; v.rdy = rdy; v.r1b = r1b; v.r1f = r1f;
        v.r2b = r2b; v.r2f = r2f; v.pidx = pidx; v.pval = pval; v.pbusy = pbusy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; wr_en = v.we; wr_sel = v.ws; wr_data = v.wd;
        iss_valid = v.iv; iss_rd = v.ird; rs1_sel = v.r1; rs2_sel = v.r2;
    endtask

    // After the clock edge: pop the expected post-edge state and compare.
    task automatic post_check(input string tag);
        post_t p;
        if (post_q.size() == 0) begin
            chk({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            p = post_q.pop_front();
            chk($sformatf("%s rf_o[%0d]", tag, p.idx), {16'd0, rf_o[p.idx]}, {16'd0, p.val});
            chk({tag, " busy_o"}, {16'd0, busy_o}, {16'd0, p.busy});
        end
    endtask

    initial begin
        post_t p;
        vec_t  v;
        logic  e_rdy, e_r1f, e_r2f;

        //            rst we ws  wd        iv ird r1 r2 cc rdy r1b r1f r2b r2f pidx pval      pbusy
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 16'hBEEF, 16'h0000);
        tbl[2]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 1, 5, 16'h1234, 0, 0, 5, 0, 1, 1, 0, 1, 0, 0, 5, 16'h1234, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 1, 7, 0, 0, 1, 1, 0, 0, 0, 0, 7, 16'h0000, 16'h0080);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 1, 7, 7, 0, 1, 0, 1, 0, 0, 0, 7, 16'h0000, 16'h0080);
        tbl[6]  = mk(0, 1, 7, 16'h7777, 1, 7, 7, 0, 1, 1, 0, 1, 0, 0, 7, 16'h7777, 16'h0080);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 2, 16'h0000, 16'h0084);
        tbl[8]  = mk(0, 1, 2, 16'h00AA, 1, 2, 2, 7, 1, 1, 0, 1, 1, 0, 2, 16'h00AA, 16'h0084);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0086);
        tbl[10] = mk(0, 1, 1, 16'h1111, 1, 9, 1, 9, 1, 1, 0, 1, 0, 0, 1, 16'h1111, 16'h0284);
        tbl[11] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0, 9, 16'h0000, 16'h0284);
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 4, 16'h0000, 16'h0294);
        tbl[13] = mk(0, 0, 0, 16'h0000, 1, 12, 0, 0, 1, 1, 0, 0, 0, 0, 4, 16'h0000, 16'h1294);
        tbl[14] = mk(1, 1, 4, 16'h4444, 0, 0, 4, 12, 1, 1, 0, 1, 1, 0, 4, 16'h0000, 16'h0000);
        tbl[15] = mk(0, 0, 0, 16'h0000, 0, 0, 4, 12, 1, 1, 0, 0, 0, 0, 4, 16'h0000, 16'h0000);
        tbl[16] = mk(0, 1, 0, 16'hFFFF, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 16'hFFFF, 16'h0001);
        tbl[17] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 16'hFFFF, 16'h0001);
        tbl[18] = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000);

        drive(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            #3;
            if (tbl[i].cc) begin
                chk($sformatf("v%0d iss_ready", i), {31'd0, iss_ready}, {31'd0, tbl[i].rdy});
                chk($sformatf("v%0d rs1_busy", i),  {31'd0, rs1_busy},  {31'd0, tbl[i].r1b});
                chk($sformatf("v%0d rs1_fwd", i),   {31'd0, rs1_fwd},   {31'd0, tbl[i].r1f});
                chk($sformatf("v%0d rs2_busy", i),  {31'd0, rs2_busy},  {31'd0, tbl[i].r2b});
                chk($sformatf("v%0d rs2_fwd", i),   {31'd0, rs2_fwd},   {31'd0, tbl[i].r2f});
            end
            p.idx = tbl[i].pidx; p.val = tbl[i].pval; p.busy = tbl[i].pbusy;
            post_q.push_back(p);
            @(posedge clk); #1;
            post_check($sformatf("v%0d", i));
        end

        // Whole array must be cleared after the final reset row.
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("clr rf_o[%0d]", r), {16'd0, rf_o[r]}, 32'd0);
        end

        // Random traffic against a behavioural model starting from the reset state.
        for (int r = 0; r < 16; r++) m_rf[r] = 16'h0000;
        m_busy = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            v = mk(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                   16'($urandom), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
            drive(v);
            #3;
            e_rdy = !m_busy[v.ird] || (v.we && v.ws == v.ird);
            e_r1f = v.we && v.ws == v.r1;
            e_r2f = v.we && v.ws == v.r2;
            chk($sformatf("r%0d iss_ready", n), {31'd0, iss_ready}, {31'd0, e_rdy});
            chk($sformatf("r%0d rs1_fwd", n),   {31'd0, rs1_fwd},   {31'd0, e_r1f});
            chk($sformatf("r%0d rs2_fwd", n),   {31'd0, rs2_fwd},   {31'd0, e_r2f});
            chk($sformatf("r%0d rs1_busy", n),  {31'd0, rs1_busy},  {31'd0, m_busy[v.r1] && !e_r1f});
            chk($sformatf("r%0d rs2_busy", n),  {31'd0, rs2_busy},  {31'd0, m_busy[v.r2] && !e_r2f});
            if (v.rst) begin
                for (int r = 0; r < 16; r++) m_rf[r] = 16'h0000;
                m_busy = 16'h0000;
            end else begin
                if (v.we) begin
                    m_rf[v.ws] = v.wd;
                    m_busy[v.ws] = 1'b0;
                end
                if (v.iv && e_rdy) m_busy[v.ird] = 1'b1;
            end
            p.idx = (n % 2 == 0) ? v.ws : 4'($urandom_range(0, 15));
            p.val = m_rf[p.idx];
            p.busy = m_busy;
            post_q.push_back(p);
            @(posedge clk); #1;
            post_check($sformatf("r%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_16x16
